// File: rtl/assoc_mem_sequencer_if.sv
// Host-command, response and memory-bus signals of the associative memory
// sequencer. The slave modport is the sequencer; the master modport is the
// host together with the memory array that returns read data.
interface assoc_mem_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  // command channel
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  // response channel
  logic              rsp_valid;
  logic              rsp_found;
  logic              rsp_error;
  logic [15:0]       rsp_addr;
  // status
  logic [15:0]       entry_count;
  logic              busy;
  // memory bus
  logic [15:0]       mem_addr;
  logic              mem_wr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, mem_rdata,
    output cmd_ready, rsp_valid, rsp_found, rsp_error, rsp_addr,
           entry_count, busy, mem_addr, mem_wr, mem_rd, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, mem_rdata,
    input  cmd_ready, rsp_valid, rsp_found, rsp_error, rsp_addr,
           entry_count, busy, mem_addr, mem_wr, mem_rd, mem_wdata
  );
endinterface

// File: rtl/assoc_mem_sequencer.sv
// Command-driven sequencer for the LFSR-addressed associative memory.
// Writes go to successive LFSR addresses starting at SEED; a search replays
// the same address sequence and stops at the first matching word or after
// every stored entry has been probed.
module assoc_mem_sequencer #(
  parameter int unsigned DATA_W   = 8,
  parameter logic [15:0] SEED     = 16'h0001,
  parameter logic [15:0] CAPACITY = 16'd65535
) (
  input logic                  clk,
  input logic                  rst,
  assoc_mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    S_READ,
    S_CHECK
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SEARCH = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  // x^16 + x^14 + x^13 + x^11 + 1 style Fibonacci step, shifting left
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  state_t            state, state_n;
  logic [15:0]       wr_lfsr, wr_lfsr_n;
  logic [15:0]       srch_lfsr, srch_lfsr_n;
  logic [DATA_W-1:0] key, key_n;
  logic [15:0]       probe, probe_n;
  logic [15:0]       entry_count, entry_count_n;
  logic              rsp_valid, rsp_valid_n;
  logic              rsp_found, rsp_found_n;
  logic              rsp_error, rsp_error_n;
  logic [15:0]       rsp_addr, rsp_addr_n;
  logic              last_probe;
  op_t               op;

  assign op         = op_t'(bus.cmd_op);
  assign last_probe = ({1'b0, probe} + 17'd1) == {1'b0, entry_count};

  // State and datapath registers; reset abandons any command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_lfsr     <= SEED;
      srch_lfsr   <= SEED;
      key         <= '0;
      probe       <= '0;
      entry_count <= '0;
      rsp_valid   <= 1'b0;
      rsp_found   <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_addr    <= '0;
    end else begin
      state       <= state_n;
      wr_lfsr     <= wr_lfsr_n;
      srch_lfsr   <= srch_lfsr_n;
      key         <= key_n;
      probe       <= probe_n;
      entry_count <= entry_count_n;
      rsp_valid   <= rsp_valid_n;
      rsp_found   <= rsp_found_n;
      rsp_error   <= rsp_error_n;
      rsp_addr    <= rsp_addr_n;
    end
  end

  // Next-state and datapath update; response fields default to zero so they
  // only carry a payload during the single Rsp_Valid cycle
  always_comb begin
    state_n       = state;
    wr_lfsr_n     = wr_lfsr;
    srch_lfsr_n   = srch_lfsr;
    key_n         = key;
    probe_n       = probe;
    entry_count_n = entry_count;
    rsp_valid_n   = 1'b0;
    rsp_found_n   = 1'b0;
    rsp_error_n   = 1'b0;
    rsp_addr_n    = '0;

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          key_n = bus.cmd_data;
          case (op)
            OP_WRITE: begin
              if (entry_count == CAPACITY) begin
                rsp_valid_n = 1'b1;
                rsp_error_n = 1'b1;
              end else begin
                state_n = WRITE;
              end
            end
            OP_SEARCH: begin
              if (entry_count == 16'd0) begin
                rsp_valid_n = 1'b1;
              end else begin
                srch_lfsr_n = SEED;
                probe_n     = '0;
                state_n     = S_READ;
              end
            end
            OP_CLEAR: begin
              // stored words are left in the array; the count alone bounds searches
              wr_lfsr_n     = SEED;
              entry_count_n = '0;
              rsp_valid_n   = 1'b1;
              rsp_found_n   = 1'b1;
            end
            default: begin
              rsp_valid_n = 1'b1;
              rsp_error_n = 1'b1;
            end
          endcase
        end
      end

      WRITE: begin
        wr_lfsr_n     = lfsr_step(wr_lfsr);
        entry_count_n = entry_count + 16'd1;
        rsp_valid_n   = 1'b1;
        rsp_found_n   = 1'b1;
        rsp_addr_n    = wr_lfsr;
        state_n       = IDLE;
      end

      S_READ: begin
        state_n = S_CHECK;
      end

      S_CHECK: begin
        if (bus.mem_rdata == key) begin
          rsp_valid_n = 1'b1;
          rsp_found_n = 1'b1;
          rsp_addr_n  = srch_lfsr;
          state_n     = IDLE;
        end else if (last_probe) begin
          rsp_valid_n = 1'b1;
          state_n     = IDLE;
        end else begin
          probe_n     = probe + 16'd1;
          srch_lfsr_n = lfsr_step(srch_lfsr);
          state_n     = S_READ;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Memory strobes and address are driven only in the states that use them
  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      WRITE: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = wr_lfsr;
        bus.mem_wdata = key;
      end
      S_READ: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = srch_lfsr;
      end
      default: begin
        bus.mem_wr = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_found   = rsp_found;
  assign bus.rsp_error   = rsp_error;
  assign bus.rsp_addr    = rsp_addr;
  assign bus.entry_count = entry_count;

endmodule

// File: tb/tb_assoc_mem_sequencer.sv
// Bench for assoc_mem_sequencer: two instances (full capacity and CAPACITY=2)
// receive identical commands; each is compared against a queue-based model
// of the stored entries.
module tb_assoc_mem_sequencer;

  localparam int unsigned BUDGET = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  assoc_mem_sequencer_if #(.DATA_W(8)) bus0 ();
  assoc_mem_sequencer_if #(.DATA_W(8)) bus1 ();

  assoc_mem_sequencer #(.DATA_W(8), .SEED(16'h0001), .CAPACITY(16'd65535)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  assoc_mem_sequencer #(.DATA_W(8), .SEED(16'h0001), .CAPACITY(16'd2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // memory arrays behind each sequencer, read data one cycle after the strobe
  logic [7:0] mem0 [65536];
  logic [7:0] mem1 [65536];
  always @(posedge clk) begin
    if (bus0.mem_wr) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    if (bus0.mem_rd) bus0.mem_rdata <= mem0[bus0.mem_addr];
    if (bus1.mem_wr) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    if (bus1.mem_rd) bus1.mem_rdata <= mem1[bus1.mem_addr];
  end

  logic        rv [2], rf [2], re [2], mwr [2], mrd [2], rdy [2], bsy [2];
  logic [15:0] ra [2], ec [2], ma [2];
  assign rv[0]  = bus0.rsp_valid;   assign rv[1]  = bus1.rsp_valid;
  assign rf[0]  = bus0.rsp_found;   assign rf[1]  = bus1.rsp_found;
  assign re[0]  = bus0.rsp_error;   assign re[1]  = bus1.rsp_error;
  assign ra[0]  = bus0.rsp_addr;    assign ra[1]  = bus1.rsp_addr;
  assign ec[0]  = bus0.entry_count; assign ec[1]  = bus1.entry_count;
  assign ma[0]  = bus0.mem_addr;    assign ma[1]  = bus1.mem_addr;
  assign mwr[0] = bus0.mem_wr;      assign mwr[1] = bus1.mem_wr;
  assign mrd[0] = bus0.mem_rd;      assign mrd[1] = bus1.mem_rd;
  assign rdy[0] = bus0.cmd_ready;   assign rdy[1] = bus1.cmd_ready;
  assign bsy[0] = bus0.busy;        assign bsy[1] = bus1.busy;

  int checks = 0;
  int errors = 0;

  // Reference state: address of the k-th entry, capacity, and stored words in write order
  logic [15:0] seq [1024];
  int          cap [2];
  logic [7:0]  store [2][$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic [1:0] op, input logic [7:0] data);
    bus0.cmd_valid = v; bus0.cmd_op = op; bus0.cmd_data = data;
    bus1.cmd_valid = v; bus1.cmd_op = op; bus1.cmd_data = data;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    drive_cmd(1'b0, 2'b00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    store[0].delete();
    store[1].delete();
  endtask

  // Expected outcome of one command; latency counts cycles after the accept edge
  task automatic model(input int d, input logic [1:0] op, input logic [7:0] data,
                       output int lat, output logic found, output logic err,
                       output logic [15:0] addr, output int rds, output int wrs);
    int n;
    int hit;
    n = store[d].size();
    lat = 1; found = 1'b0; err = 1'b0; addr = 16'h0; rds = 0; wrs = 0;
    case (op)
      2'b00: begin
        if (n == cap[d]) err = 1'b1;
        else begin
          lat = 2; found = 1'b1; addr = seq[n]; wrs = 1;
          store[d].push_back(data);
        end
      end
      2'b01: begin
        if (n > 0) begin
          hit = -1;
          for (int i = 0; i < n; i++)
            if (hit < 0 && store[d][i] == data) hit = i;
          if (hit >= 0) begin
            lat = 3 + 2 * hit; found = 1'b1; addr = seq[hit]; rds = hit + 1;
          end else begin
            lat = 2 * n + 1; rds = n;
          end
        end
      end
      2'b10: begin
        found = 1'b1;
        store[d].delete();
      end
      default: err = 1'b1;
    endcase
  endtask

  // Issue one command to both instances (both idle) and check everything it does
  task automatic issue(input logic [1:0] op, input logic [7:0] data,
                       output logic [15:0] addr0, output int lat0);
    int          e_lat [2], e_rds [2], e_wrs [2];
    logic        e_f [2], e_e [2];
    logic [15:0] e_a [2];
    int          g_lat [2], g_rds [2], g_wrs [2], rd_bad [2];
    logic        g_f [2], g_e [2], done [2];
    logic [15:0] g_a [2], g_ec [2], g_wa [2], g_ma [2];
    for (int d = 0; d < 2; d++) begin
      model(d, op, data, e_lat[d], e_f[d], e_e[d], e_a[d], e_rds[d], e_wrs[d]);
      g_lat[d] = 0; g_rds[d] = 0; g_wrs[d] = 0; rd_bad[d] = 0; done[d] = 1'b0;
      g_f[d] = 1'b0; g_e[d] = 1'b0; g_a[d] = '0; g_ec[d] = '0; g_wa[d] = '0; g_ma[d] = '0;
    end
    drive_cmd(1'b1, op, data);
    @(posedge clk);
    #1;
    drive_cmd(1'b0, op, data);
    for (int cyc = 1; cyc <= int'(BUDGET); cyc++) begin
      for (int d = 0; d < 2; d++) begin
        if (!done[d]) begin
          if (rv[d]) begin
            done[d] = 1'b1; g_lat[d] = cyc;
            g_f[d] = rf[d]; g_e[d] = re[d]; g_a[d] = ra[d]; g_ec[d] = ec[d]; g_ma[d] = ma[d];
          end else begin
            if (mwr[d]) begin g_wrs[d]++; g_wa[d] = ma[d]; end
            if (mrd[d]) begin
              if (g_rds[d] >= 1024 || ma[d] != seq[g_rds[d]]) rd_bad[d]++;
              g_rds[d]++;
            end
          end
        end
      end
      if (done[0] && done[1]) break;
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_op%0d_responded", d, op), done[d], 1'b1);
      check_eq($sformatf("d%0d_op%0d_latency", d, op), g_lat[d], e_lat[d]);
      check_eq($sformatf("d%0d_op%0d_found", d, op), g_f[d], e_f[d]);
      check_eq($sformatf("d%0d_op%0d_error", d, op), g_e[d], e_e[d]);
      check_eq($sformatf("d%0d_op%0d_rsp_addr", d, op), g_a[d], e_a[d]);
      check_eq($sformatf("d%0d_op%0d_entry_count", d, op), g_ec[d], store[d].size());
      check_eq($sformatf("d%0d_op%0d_read_strobes", d, op), g_rds[d], e_rds[d]);
      check_eq($sformatf("d%0d_op%0d_read_addr_errs", d, op), rd_bad[d], 0);
      check_eq($sformatf("d%0d_op%0d_write_strobes", d, op), g_wrs[d], e_wrs[d]);
      if (e_wrs[d] == 1) check_eq($sformatf("d%0d_write_addr", d), g_wa[d], e_a[d]);
      check_eq($sformatf("d%0d_op%0d_idle_mem_addr", d, op), g_ma[d], 16'h0);
    end
    addr0 = g_a[0];
    lat0  = g_lat[0];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rsp_cleared_valid", d), rv[d], 1'b0);
      check_eq($sformatf("d%0d_rsp_cleared_addr", d), ra[d], 16'h0);
      check_eq($sformatf("d%0d_ready_after", d), rdy[d], 1'b1);
    end
  endtask

  initial begin
    logic [15:0] a;
    int          l;
    int          n;
    int          hit_cyc;
    int          wr_seen;
    int          pulses;
    logic [1:0]  op;
    logic [7:0]  data;
    int          r;

    seq[0] = 16'h0001;
    for (int i = 1; i < 1024; i++)
      seq[i] = {seq[i-1][14:0], seq[i-1][15] ^ seq[i-1][13] ^ seq[i-1][12] ^ seq[i-1][10]};
    cap[0] = 65535;
    cap[1] = 2;
    bus0.mem_rdata = '0;
    bus1.mem_rdata = '0;

    reset_all();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_reset_ready", d), rdy[d], 1'b1);
      check_eq($sformatf("d%0d_reset_busy", d), bsy[d], 1'b0);
      check_eq($sformatf("d%0d_reset_rsp_valid", d), rv[d], 1'b0);
      check_eq($sformatf("d%0d_reset_count", d), ec[d], 16'h0);
      check_eq($sformatf("d%0d_reset_mem_addr", d), ma[d], 16'h0);
      check_eq($sformatf("d%0d_reset_strobes", d), {mwr[d], mrd[d]}, 2'b00);
    end

    // directed sequence from the block's usage scenarios
    issue(2'b00, 8'hA5, a, l); check_eq("tp_write1_addr", a, 16'h0001);
    issue(2'b00, 8'h3C, a, l); check_eq("tp_write2_addr", a, 16'h0002);
    issue(2'b00, 8'h77, a, l); check_eq("tp_write3_addr", a, 16'h0004);
    check_eq("tp_count3", ec[0], 16'd3);
    check_eq("tp_small_count_capped", ec[1], 16'd2);
    // "6 cycles after accept": response rises on the sixth edge after the accept edge
    issue(2'b01, 8'h77, a, l); check_eq("tp_hit_addr", a, 16'h0004); check_eq("tp_hit_delay", l - 1, 6);
    issue(2'b01, 8'h99, a, l); check_eq("tp_miss_addr", a, 16'h0000); check_eq("tp_miss_delay", l - 1, 6);
    issue(2'b10, 8'h00, a, l); check_eq("tp_clear_count", ec[0], 16'h0);
    issue(2'b01, 8'h77, a, l); check_eq("tp_empty_search_lat", l, 1);
    issue(2'b00, 8'h11, a, l);
    issue(2'b00, 8'h11, a, l);
    issue(2'b01, 8'h11, a, l); check_eq("tp_dup_first_wins", a, 16'h0001);
    issue(2'b10, 8'h00, a, l);
    issue(2'b00, 8'h42, a, l); check_eq("tp_write_after_clear", a, 16'h0001);
    issue(2'b11, 8'h42, a, l);

    // randomized command mix, small key space so duplicates and hits are common
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      op = (r < 50) ? 2'b00 : (r < 85) ? 2'b01 : (r < 93) ? 2'b10 : 2'b11;
      data = 8'($urandom_range(0, 15));
      if (op == 2'b01 && store[0].size() > 0 && $urandom_range(0, 1) == 1)
        data = store[0][$urandom_range(0, store[0].size() - 1)];
      issue(op, data, a, l);
    end

    // command held valid while busy is only taken once ready returns
    reset_all();
    issue(2'b00, 8'h21, a, l);
    issue(2'b00, 8'h22, a, l);
    issue(2'b00, 8'h23, a, l);
    n = store[0].size();
    drive_cmd(1'b1, 2'b01, 8'hEE);
    @(posedge clk);
    #1;
    drive_cmd(1'b1, 2'b00, 8'h5A);
    hit_cyc = 0;
    wr_seen = 0;
    for (int cyc = 1; cyc <= int'(BUDGET); cyc++) begin
      if (rv[0]) begin hit_cyc = cyc; break; end
      if (mwr[0]) wr_seen++;
      @(posedge clk);
      #1;
    end
    check_eq("hold_search_lat", hit_cyc, 2 * n + 1);
    check_eq("hold_search_found", rf[0], 1'b0);
    check_eq("hold_no_early_write", wr_seen, 0);
    @(posedge clk);
    #1;
    drive_cmd(1'b0, 2'b00, 8'h00);
    check_eq("hold_write_strobe", mwr[0], 1'b1);
    check_eq("hold_write_addr", ma[0], seq[n]);
    @(posedge clk);
    #1;
    check_eq("hold_write_rsp", rv[0], 1'b1);
    check_eq("hold_write_rsp_addr", ra[0], seq[n]);
    check_eq("hold_write_count", ec[0], 16'(n + 1));

    // reset while a search sits in S_CHECK
    reset_all();
    issue(2'b00, 8'h31, a, l);
    issue(2'b00, 8'h32, a, l);
    issue(2'b00, 8'h33, a, l);
    drive_cmd(1'b1, 2'b01, 8'hEE);
    @(posedge clk);
    #1;
    drive_cmd(1'b0, 2'b00, 8'h00);
    @(posedge clk);
    #1;
    check_eq("mid_search_busy", bsy[0], 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_ready", rdy[0], 1'b1);
    check_eq("rst_mid_busy", bsy[0], 1'b0);
    check_eq("rst_mid_count", ec[0], 16'h0);
    check_eq("rst_mid_rsp_valid", rv[0], 1'b0);
    check_eq("rst_mid_mem_rd", mrd[0], 1'b0);
    rst = 1'b0;
    store[0].delete();
    store[1].delete();
    pulses = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk);
      #1;
      if (rv[0] || rv[1]) pulses++;
    end
    check_eq("rst_mid_no_late_rsp", pulses, 0);
    issue(2'b00, 8'h44, a, l);
    check_eq("rst_mid_next_write_addr", a, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_mem_sequencer.md
# assoc_mem_sequencer

Command-driven sequencer for the LFSR-addressed associative memory. It accepts write, search and clear commands over a valid/ready handshake. It generates the pseudo-random memory addresses from an internal 16-bit LFSR and drives the memory's write and read strobes. On a search it replays the LFSR from the seed and compares each stored word against the key, stopping at the first match or once every written entry has been probed. It sits between the external host and the memory array and replaces the free-running external read/write strobes with a single-clock, handshaked control flow.

## Interface
- DATA_W, 8: width of stored words and search key.
- SEED, 16'h0001: LFSR start value and first write address. Must be nonzero.
- CAPACITY, 16'd65535: maximum number of stored entries. Must be ≤ 65535 (the LFSR period).
- Clock  in  1  single clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high.
- Cmd_Valid  in  1  a command is offered.
- Cmd_Op  in  2  00 = write, 01 = search, 10 = clear, 11 = reserved.
- Cmd_Data  in  DATA_W  write data or search key.
- Cmd_Ready  out  1  high only in IDLE; a command is accepted when Cmd_Valid & Cmd_Ready.
- Rsp_Valid  out  1  one-cycle response pulse.
- Rsp_Found  out  1  search hit. Write/clear responses set it to 1 on success.
- Rsp_Error  out  1  write when full, or reserved op.
- Rsp_Addr  out  16  address written (write) or matched (search); 0 otherwise.
- Entry_Count  out  16  number of entries currently stored.
- Busy  out  1  high whenever the FSM is not in IDLE.
- Mem_Addr  out  16  memory address.
- Mem_WR  out  1  write strobe, one cycle.
- Mem_RD  out  1  read strobe, one cycle.
- Mem_Wdata  out  DATA_W  write data.
- Mem_Rdata  in  DATA_W  read data, valid one cycle after Mem_RD.

## Operation
- **States:** IDLE, WRITE, S_READ, S_CHECK.
- **LFSR next-state function:** fb = q[15]^q[13]^q[12]^q[10]; next = {q[14:0], fb}. From 0x0001 the sequence is 0x0002, 0x0004, …, 0x0400, then 0x0801.
- **Registers:**
  - wr_lfsr: next free address; reset to SEED.
  - srch_lfsr: probe address.
  - key register.
  - 16-bit probe counter.
  - Entry_Count.
- **On accept, Cmd_Data is latched into the key register.**
- **Write:**
  - Entry_Count == CAPACITY → stay in IDLE, respond with Error=1; no memory access.
  - Otherwise go to WRITE: Mem_WR=1, Mem_Addr=wr_lfsr, Mem_Wdata=key. Then wr_lfsr advances, Entry_Count increments, and the FSM responds with Rsp_Addr = the written address.
- **Search:**
  - Entry_Count == 0 → stay in IDLE, respond with Found=0.
  - Otherwise srch_lfsr=SEED, probe=0, go to S_READ.
  - S_READ: Mem_RD=1, Mem_Addr=srch_lfsr, go to S_CHECK.
  - S_CHECK on match (Mem_Rdata == key): respond with Found=1, Rsp_Addr=srch_lfsr.
  - S_CHECK on miss with probe+1 == Entry_Count: respond with Found=0.
  - S_CHECK on any other miss: probe++, srch_lfsr advances, go to S_READ.
  - Duplicate keys: the earliest-written entry wins.
- **Clear:** wr_lfsr=SEED, Entry_Count=0, respond with Found=1. Memory contents are not erased.
- **Reserved op:** respond with Error=1; no state change.
- **Idle memory bus:** Mem_WR, Mem_RD and Mem_Addr are 0 whenever the FSM is not driving them.
- **Reset:** valid in any state, including mid-search. It returns the FSM to IDLE and sets every output to 0, except Cmd_Ready=1. wr_lfsr=SEED and Entry_Count=0. Any in-flight command produces no response.

## Timing
- Command accepted at edge T.
- **Write:** WRITE state during cycle T+1. Rsp_Valid during T+2 with the FSM back in IDLE and Cmd_Ready=1, so back-to-back writes run every 2 cycles.
- **Search, probe k (0-based):**
  - S_READ during T+1+2k, S_CHECK during T+2+2k.
  - Hit at probe k → Rsp_Valid at T+3+2k.
  - Miss over N entries → Rsp_Valid at T+2N+1.
- **Immediate responses at T+1:** empty search, full write, clear, reserved op.
- **Response payload:** Rsp_* fields are registered and stable only while Rsp_Valid is high, then return to 0.
- **Entry_Count:** updates in the same cycle Rsp_Valid rises.

## Test plan
- After reset, write 0xA5, 0x3C, 0x77 → responses with Rsp_Addr 0x0001, 0x0002, 0x0004. Mem_WR is one cycle per write. Entry_Count reaches 3.
- Search 0x77 → Mem_RD at addresses 0x0001, 0x0002, 0x0004. Rsp_Found=1, Rsp_Addr=0x0004, Rsp_Valid exactly 6 cycles after accept.
- Search 0x99 with 3 entries → Rsp_Found=0, Rsp_Addr=0, Rsp_Valid 6 cycles after accept. Search on an empty memory → Found=0 at T+1 with no Mem_RD.
- Write 0x11 twice, then search 0x11 → Rsp_Addr=0x0001 (first entry wins). Clear → Entry_Count=0. The next write goes to 0x0001.
- CAPACITY=2: a third write → Rsp_Error=1, no Mem_WR, Entry_Count stays 2. Cmd_Op=11 → Rsp_Error=1.
- Assert Reset during S_CHECK of a search → the following cycle shows IDLE, Cmd_Ready=1, Entry_Count=0, no Rsp_Valid. Cmd_Valid held while Busy → not accepted until Cmd_Ready rises.
